// File: rtl/spi_bridge_pkg.sv
// Shared types and helpers for the SPI-to-peripheral-register bridge:
// FSM states, transaction width codes, header layout and beat arithmetic.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_SHIFT,
        S_HALT
    } state_e;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_NONE = 2'b11;

    localparam int HDR_BITS = 16;
    localparam int HDR_RW   = 15;
    localparam int HDR_W_HI = 14;
    localparam int HDR_W_LO = 13;

    // Host clocks this many dummy SCLK cycles ahead of every read beat.
    localparam logic [5:0] RD_DUMMY = 6'd8;

    function automatic logic [5:0] beat_bits(input logic [1:0] w);
        case (w)
            W_BYTE:  beat_bits = 6'd8;
            W_HALF:  beat_bits = 6'd16;
            default: beat_bits = 6'd32;
        endcase
    endfunction

    function automatic logic [2:0] byte_incr(input logic [1:0] w);
        case (w)
            W_BYTE:  byte_incr = 3'd1;
            W_HALF:  byte_incr = 3'd2;
            default: byte_incr = 3'd4;
        endcase
    endfunction

    // Keeps only the transaction-width bits and parks them at the top so the
    // shifter always sends bit 31 first.
    function automatic logic [31:0] align_msb(input logic [1:0] w, input logic [31:0] d);
        case (w)
            W_BYTE:  align_msb = {d[7:0], 24'h0};
            W_HALF:  align_msb = {d[15:0], 16'h0};
            default: align_msb = d;
        endcase
    endfunction

endpackage

// File: rtl/spi_bridge_sync.sv
// Two-flop synchroniser for one raw SPI pin, with a third flop for
// rising/falling edge detection in the clk domain.
module spi_bridge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: non-blocking assignments keep this a true shift chain; blocking
    // ones would collapse the three stages into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_periph_bridge.sv
// SPI slave that decodes a 16-bit header and runs auto-incrementing burst
// reads/writes onto up to N_PERIPH TinyQV-style peripheral register buses.
module spi_periph_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int N_PERIPH = 2,
    parameter int SEL_W    = 3,
    parameter int TIMEOUT  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_cs_n,
    input  logic                   spi_clk,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic [ADDR_W-1:0]      address,
    output logic [31:0]            data_in,
    output logic [2*N_PERIPH-1:0]  data_write_n,
    output logic [2*N_PERIPH-1:0]  data_read_n,
    input  logic [32*N_PERIPH-1:0] data_out,
    input  logic [N_PERIPH-1:0]    data_ready,
    input  logic [N_PERIPH-1:0]    user_interrupt,
    output logic                   irq,
    output logic                   err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic cs_n_s, cs_fall, cs_rise_unused;
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_bridge_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n),
        .q_o(cs_n_s), .rise_o(cs_rise_unused), .fall_o(cs_fall)
    );
    spi_bridge_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(spi_clk),
        .q_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_bridge_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(spi_mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_e                state_q, state_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [14:0]           hdr_q, hdr_d;
    logic [1:0]            width_q, width_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic [31:0]           wsh_q, wsh_d;
    logic [31:0]           shreg_q, shreg_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  miso_q, miso_d;
    logic [31:0]           data_in_q, data_in_d;
    logic [2*N_PERIPH-1:0] data_write_n_q, data_write_n_d;
    logic [2*N_PERIPH-1:0] data_read_n_q, data_read_n_d;
    logic                  irq_q, irq_d;
    logic                  err_q, err_d;

    logic [15:0]       hdr_next;
    logic [1:0]        width_new;
    logic [SEL_W-1:0]  sel_new;
    logic [ADDR_W-1:0] addr_new;
    logic [ADDR_W-1:0] addr_inc;
    logic [5:0]        data_last;
    logic [5:0]        rd_beat_last;
    logic [31:0]       wdata_next;

    assign hdr_next     = {hdr_q, mosi_s};
    assign width_new    = hdr_next[HDR_W_HI:HDR_W_LO];
    assign sel_new      = hdr_next[ADDR_W+SEL_W-1 -: SEL_W];
    assign addr_new     = hdr_next[ADDR_W-1:0];
    assign addr_inc     = address_q + ADDR_W'(byte_incr(width_q));
    assign data_last    = beat_bits(width_q) - 6'd1;
    assign rd_beat_last = RD_DUMMY + data_last;
    assign wdata_next   = {wsh_q[30:0], mosi_s};

    // NOTE: every *_d gets a default before the case so no path through this
    // block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        hdr_d          = hdr_q;
        width_d        = width_q;
        sel_d          = sel_q;
        address_d      = address_q;
        wsh_d          = wsh_q;
        shreg_d        = shreg_q;
        timer_d        = timer_q;
        miso_d         = miso_q;
        data_in_d      = data_in_q;
        data_write_n_d = '1;
        data_read_n_d  = data_read_n_q;
        irq_d          = |user_interrupt;
        err_d          = err_q;

        // Advance only once the one-cycle write strobe has been seen at the old address.
        if (data_write_n_q != '1) address_d = addr_inc;

        case (state_q)
            S_IDLE: begin
                miso_d        = 1'b0;
                data_read_n_d = '1;
                if (cs_fall) begin
                    state_d   = S_HDR;
                    bit_cnt_d = '0;
                end
            end
            S_HDR: if (sclk_rise) begin
                hdr_d     = hdr_next[14:0];
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'(HDR_BITS - 1)) begin
                    width_d   = width_new;
                    sel_d     = sel_new;
                    address_d = addr_new;
                    bit_cnt_d = '0;
                    wsh_d     = '0;
                    timer_d   = '0;
                    if (hdr_next[HDR_RW] && sel_new == '1 && addr_new == '0) begin
                        err_d   = 1'b0;
                        state_d = S_HALT;
                    end else if (width_new == W_NONE || int'(sel_new) >= N_PERIPH) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else if (hdr_next[HDR_RW]) begin
                        state_d = S_WDATA;
                    end else begin
                        data_read_n_d[int'(sel_new)*2 +: 2] = width_new;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WDATA: if (sclk_rise) begin
                wsh_d     = wdata_next;
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == data_last) begin
                    data_in_d = wdata_next;
                    data_write_n_d[int'(sel_q)*2 +: 2] = width_q;
                    wsh_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            S_RD_REQ, S_RD_WAIT: begin
                if (sclk_rise) bit_cnt_d = bit_cnt_q + 6'd1;
                if (data_ready[sel_q]) begin
                    shreg_d       = align_msb(width_q, data_out[int'(sel_q)*32 +: 32]);
                    data_read_n_d = '1;
                    state_d       = S_RD_SHIFT;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    shreg_d       = '0;
                    data_read_n_d = '1;
                    err_d         = 1'b1;
                    state_d       = S_RD_SHIFT;
                end else begin
                    timer_d = timer_q + 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_SHIFT: begin
                // Bit k of the beat goes out on the fall that precedes rise 9+k.
                if (sclk_fall && bit_cnt_q >= RD_DUMMY && bit_cnt_q <= rd_beat_last) begin
                    miso_d  = shreg_q[31];
                    shreg_d = {shreg_q[30:0], 1'b0};
                end
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == rd_beat_last) begin
                        bit_cnt_d = '0;
                        address_d = addr_inc;
                        timer_d   = '0;
                        data_read_n_d[int'(sel_q)*2 +: 2] = width_q;
                        state_d   = S_RD_REQ;
                    end
                end
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase

        // Chip-select release aborts any partial beat or pending read.
        if (cs_n_s && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            bit_cnt_d      = '0;
            wsh_d          = '0;
            data_write_n_d = '1;
            data_read_n_d  = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            hdr_q          <= '0;
            width_q        <= W_BYTE;
            sel_q          <= '0;
            address_q      <= '0;
            wsh_q          <= '0;
            shreg_q        <= '0;
            timer_q        <= '0;
            miso_q         <= 1'b0;
            data_in_q      <= '0;
            data_write_n_q <= '1;
            data_read_n_q  <= '1;
            irq_q          <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            hdr_q          <= hdr_d;
            width_q        <= width_d;
            sel_q          <= sel_d;
            address_q      <= address_d;
            wsh_q          <= wsh_d;
            shreg_q        <= shreg_d;
            timer_q        <= timer_d;
            miso_q         <= miso_d;
            data_in_q      <= data_in_d;
            data_write_n_q <= data_write_n_d;
            data_read_n_q  <= data_read_n_d;
            irq_q          <= irq_d;
            err_q          <= err_d;
        end
    end

    assign spi_miso     = miso_q;
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = data_write_n_q;
    assign data_read_n  = data_read_n_q;
    assign irq          = irq_q;
    assign err          = err_q;

endmodule

// File: tb/tb_spi_periph_bridge.sv
// Directed bench for spi_periph_bridge: drives SPI frames from the host side,
// logs peripheral strobes, and models peripheral 0's data_ready delay.
module tb_spi_periph_bridge;

    localparam int ADDR_W   = 6;
    localparam int N_PERIPH = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   spi_cs_n = 1'b1;
    logic                   spi_clk = 1'b0;
    logic                   spi_mosi = 1'b0;
    logic                   spi_miso;
    logic [ADDR_W-1:0]      address;
    logic [31:0]            data_in;
    logic [2*N_PERIPH-1:0]  data_write_n;
    logic [2*N_PERIPH-1:0]  data_read_n;
    logic [32*N_PERIPH-1:0] data_out = {32'hCAFE_F00D, 32'h1234_5678};
    logic [N_PERIPH-1:0]    data_ready = '0;
    logic [N_PERIPH-1:0]    user_interrupt = '0;
    logic                   irq;
    logic                   err;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_delay = 3;

    logic [ADDR_W-1:0]     wr_addr_q[$];
    logic [31:0]           wr_data_q[$];
    logic [2*N_PERIPH-1:0] wr_n_q[$];
    int                    wr_len_q[$];
    logic [ADDR_W-1:0]     rd_addr_q[$];
    logic [2*N_PERIPH-1:0] rd_n_q[$];
    int                    rd_len_q[$];

    spi_periph_bridge #(
        .ADDR_W(ADDR_W), .N_PERIPH(N_PERIPH), .SEL_W(3), .TIMEOUT(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt), .irq(irq), .err(err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Peripheral 0 responder plus strobe logger, all sampled on the falling clk edge.
    initial begin
        int rdy_cnt = 0;
        int wr_cur = 0;
        int rd_cur = 0;
        forever begin
            @(negedge clk);
            if (data_read_n[1:0] != 2'b11) begin
                rdy_cnt++;
                data_ready[0] = (rdy_delay >= 0) && (rdy_cnt >= rdy_delay);
            end else begin
                rdy_cnt = 0;
                data_ready[0] = 1'b0;
            end
            if (data_write_n != '1) begin
                if (wr_cur == 0) begin
                    wr_addr_q.push_back(address);
                    wr_data_q.push_back(data_in);
                    wr_n_q.push_back(data_write_n);
                end
                wr_cur++;
            end else if (wr_cur != 0) begin
                wr_len_q.push_back(wr_cur);
                wr_cur = 0;
            end
            if (data_read_n != '1) begin
                if (rd_cur == 0) begin
                    rd_addr_q.push_back(address);
                    rd_n_q.push_back(data_read_n);
                end
                rd_cur++;
            end else if (rd_cur != 0) begin
                rd_len_q.push_back(rd_cur);
                rd_cur = 0;
            end
        end
    end

    // Mode 0, MSB first, SCLK period of 16 clk.
    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (8) @(negedge clk);
            spi_clk = 1'b1;
            rx = {rx[30:0], spi_miso};
            repeat (8) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rx;
        int wb;
        int rb;

        repeat (3) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data_in", data_in, 32'd0);
        check("rst_write_n", 32'(data_write_n), 32'hF);
        check("rst_read_n", 32'(data_read_n), 32'hF);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Word write to peripheral 1, address 5.
        wb = wr_addr_q.size();
        cs_begin();
        spi_bits(32'hC045, 16, rx);
        spi_bits(32'hA5A5_5A5A, 32, rx);
        cs_end();
        check("wword_count", 32'(wr_addr_q.size() - wb), 32'd1);
        check("wword_addr", 32'(wr_addr_q[wb]), 32'd5);
        check("wword_data", wr_data_q[wb], 32'hA5A5_5A5A);
        check("wword_strobe", 32'(wr_n_q[wb]), 32'b1011);
        check("wword_len", 32'(wr_len_q[wb]), 32'd1);

        // Byte read from peripheral 0, address 3, ready after 3 cycles.
        rdy_delay = 3;
        rb = rd_addr_q.size();
        cs_begin();
        spi_bits(32'h0003, 16, rx);
        spi_bits(32'h0, 16, rx);
        cs_end();
        check("rbyte_data", 32'(rx[7:0]), 32'h78);
        check("rbyte_addr", 32'(rd_addr_q[rb]), 32'd3);
        check("rbyte_req", 32'(rd_n_q[rb]), 32'b1100);
        check("rbyte_len", 32'(rd_len_q[rb]), 32'd3);
        check("rbyte_released", 32'(data_read_n), 32'hF);
        check("rbyte_err", 32'(err), 32'd0);

        // Half-word burst of three starting at address 62 wraps to 0 and 2.
        wb = wr_addr_q.size();
        cs_begin();
        spi_bits(32'hA03E, 16, rx);
        spi_bits(32'h1111, 16, rx);
        spi_bits(32'h2222, 16, rx);
        spi_bits(32'h3333, 16, rx);
        cs_end();
        check("whalf_count", 32'(wr_addr_q.size() - wb), 32'd3);
        check("whalf_addr0", 32'(wr_addr_q[wb]), 32'd62);
        check("whalf_addr1", 32'(wr_addr_q[wb+1]), 32'd0);
        check("whalf_addr2", 32'(wr_addr_q[wb+2]), 32'd2);
        check("whalf_data1", wr_data_q[wb+1], 32'h0000_2222);
        check("whalf_strobe", 32'(wr_n_q[wb]), 32'b1101);

        // Read that never gets data_ready: 32-cycle timeout, zero data, err set.
        rdy_delay = -1;
        rb = rd_len_q.size();
        cs_begin();
        spi_bits(32'h0007, 16, rx);
        spi_bits(32'h0, 16, rx);
        check("tmo_err", 32'(err), 32'd1);
        cs_end();
        check("tmo_data", 32'(rx[7:0]), 32'h00);
        check("tmo_len", 32'(rd_len_q[rb]), 32'd32);
        check("tmo_abort_released", 32'(data_read_n), 32'hF);

        // Write aborted after 20 of 32 data bits issues nothing.
        wb = wr_addr_q.size();
        cs_begin();
        spi_bits(32'hC045, 16, rx);
        spi_bits(32'hF_FFFF, 20, rx);
        cs_end();
        check("abort_no_strobe", 32'(wr_addr_q.size() - wb), 32'd0);

        // Following transaction decodes normally; err stays sticky.
        wb = wr_addr_q.size();
        cs_begin();
        spi_bits(32'hC00A, 16, rx);
        spi_bits(32'hDEAD_BEEF, 32, rx);
        cs_end();
        check("after_abort_addr", 32'(wr_addr_q[wb]), 32'd10);
        check("after_abort_data", wr_data_q[wb], 32'hDEAD_BEEF);
        check("after_abort_strobe", 32'(wr_n_q[wb]), 32'b1110);
        check("err_sticky", 32'(err), 32'd1);

        // Clear write: select all-ones, address 0.
        wb = wr_addr_q.size();
        cs_begin();
        spi_bits(32'h81C0, 16, rx);
        cs_end();
        check("err_cleared", 32'(err), 32'd0);
        check("clear_no_strobe", 32'(wr_addr_q.size() - wb), 32'd0);

        // Reset while the read is waiting on data_ready.
        rdy_delay = -1;
        cs_begin();
        spi_bits(32'h0003, 16, rx);
        repeat (4) @(negedge clk);
        check("wait_req_held", 32'(data_read_n), 32'b1100);
        rst_n = 1'b0;
        #1;
        check("rstmid_read_n", 32'(data_read_n), 32'hF);
        check("rstmid_write_n", 32'(data_write_n), 32'hF);
        check("rstmid_address", 32'(address), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rstmid_idle_read_n", 32'(data_read_n), 32'hF);

        // Select 2 is beyond N_PERIPH: no strobe, err set.
        wb = wr_addr_q.size();
        cs_begin();
        spi_bits(32'h8081, 16, rx);
        spi_bits(32'hFF, 8, rx);
        cs_end();
        check("badsel_no_strobe", 32'(wr_addr_q.size() - wb), 32'd0);
        check("badsel_err", 32'(err), 32'd1);

        // Interrupt aggregation is one register stage.
        user_interrupt = 2'b10;
        #1;
        check("irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'd1);
        user_interrupt = 2'b00;
        @(negedge clk);
        check("irq_clear", 32'(irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
